// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP,
    UART_BREAK
  } uart_state;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } uart_parity_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg, input logic [3:0] max_bits);
    if (cfg < 4'd5) return 4'd5;
    if (cfg > max_bits) return max_bits;
    return cfg;
  endfunction

  // Encoding 3 is reserved and behaves like no parity.
  function automatic uart_parity_t decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'd1:    return PARITY_EVEN;
      2'd2:    return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX character FIFO with show-ahead head, occupancy count and full/empty flags.
module uart_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_framed.sv
// FIFO-buffered UART transmitter with run-time frame format and internal baud divider.
// Optional line BREAK generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int DIV_WIDTH     = 16,
  parameter int BREAK_BITS    = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [MAX_DATA_BITS-1:0]      wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          brk_req,
  output logic                          brk_done,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CNT_W = ($clog2(BREAK_BITS + 1) > 4) ? $clog2(BREAK_BITS + 1) : 4;

  logic                     fifo_full, fifo_empty, pop, brk_go;
  logic [MAX_DATA_BITS-1:0] head, data_mask, masked;
  logic [3:0]               nbits_in;
  uart_parity_t             parity_in;

  uart_state                state_q;
  uart_parity_t             par_q;
  logic                     stop2_q, par_bit_q, tx_q, busy_q, frame_done_q;
  logic [3:0]               nbits_q;
  logic [DIV_WIDTH-1:0]     div_q, timer_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [MAX_DATA_BITS-1:0] sh_q;

  logic bit_end, last_data, last_stop, enter_final, frame_final_next;

  uart_tx_fifo #(.WIDTH(MAX_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_valid),
    .data_i  (wr_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign nbits_in  = clamp_data_bits(cfg_data_bits, 4'(MAX_DATA_BITS));
  assign parity_in = decode_parity(cfg_parity);

  for (genvar gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
    assign data_mask[gi] = (nbits_in > 4'(gi));
  end
  assign masked = head & data_mask;

  assign bit_end   = (timer_q == '0);
  assign last_data = (cnt_q == CNT_W'(nbits_q - 4'd1));
  assign last_stop = (state_q == UART_STOP) && (cnt_q == '0);
  assign pop       = !fifo_empty &&
                     (((state_q == UART_IDLE) && !brk_go) || (last_stop && bit_end));

  // Pulses are registered, so they are raised on the edge that enters the final cycle.
  assign enter_final = bit_end &&
      (((state_q == UART_DATA) && last_data && (par_q == PARITY_NONE) && !stop2_q) ||
       ((state_q == UART_PARITY) && !stop2_q) ||
       ((state_q == UART_STOP) && (cnt_q == CNT_W'(1))));
  assign frame_final_next = (last_stop && (timer_q == DIV_WIDTH'(1))) ||
                            (enter_final && (div_q == '0));

`ifdef UART_TX_BREAK_EN
  logic brk_done_q, brk_final_next;
  assign brk_go = brk_req;
  assign brk_final_next = (state_q == UART_BREAK) &&
      (((cnt_q == '0) && (timer_q == DIV_WIDTH'(1))) ||
       (bit_end && (cnt_q == CNT_W'(1)) && (div_q == '0)));
  assign brk_done = brk_done_q;
`else
  // Break support compiled out: the request is deliberately discarded.
  assign brk_go   = brk_req & 1'b0;
  assign brk_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= UART_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timer_q      <= '0;
      cnt_q        <= '0;
      div_q        <= '0;
      nbits_q      <= 4'd5;
      par_q        <= PARITY_NONE;
      stop2_q      <= 1'b0;
      par_bit_q    <= 1'b0;
      sh_q         <= '0;
`ifdef UART_TX_BREAK_EN
      brk_done_q   <= 1'b0;
`endif
    end else begin
      frame_done_q <= frame_final_next;
`ifdef UART_TX_BREAK_EN
      brk_done_q   <= brk_final_next;
`endif
      if (pop) begin
        state_q   <= UART_START;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        div_q     <= baud_div;
        timer_q   <= baud_div;
        nbits_q   <= nbits_in;
        par_q     <= parity_in;
        stop2_q   <= cfg_stop2;
        sh_q      <= masked;
        par_bit_q <= (^masked) ^ (parity_in == PARITY_ODD);
      end else begin
        timer_q <= bit_end ? div_q : timer_q - DIV_WIDTH'(1);
        case (state_q)
          UART_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            if (brk_go) begin
              state_q <= UART_BREAK;
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
              div_q   <= baud_div;
              timer_q <= baud_div;
              cnt_q   <= CNT_W'(BREAK_BITS);
            end
`endif
          end
          UART_START: if (bit_end) begin
            state_q <= UART_DATA;
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            cnt_q   <= '0;
          end
          UART_DATA: if (bit_end) begin
            if (!last_data) begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              cnt_q <= cnt_q + CNT_W'(1);
            end else if (par_q == PARITY_NONE) begin
              state_q <= UART_STOP;
              tx_q    <= 1'b1;
              cnt_q   <= stop2_q ? CNT_W'(1) : '0;
            end else begin
              state_q <= UART_PARITY;
              tx_q    <= par_bit_q;
            end
          end
          UART_PARITY: if (bit_end) begin
            state_q <= UART_STOP;
            tx_q    <= 1'b1;
            cnt_q   <= stop2_q ? CNT_W'(1) : '0;
          end
          UART_STOP: if (bit_end) begin
            if (cnt_q == '0) begin
              state_q <= UART_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
`ifdef UART_TX_BREAK_EN
          // cnt_q counts remaining low bits; zero marks the high guard bit.
          UART_BREAK: if (bit_end) begin
            if (cnt_q == '0) begin
              state_q <= UART_IDLE;
              busy_q  <= 1'b0;
            end else begin
              if (cnt_q == CNT_W'(1)) tx_q <= 1'b1;
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
`endif
          default: begin
            state_q <= UART_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed self-checking bench for uart_tx_framed; break test active with UART_TX_BREAK_EN.
module tb_uart_tx_framed;
  localparam int MDB = 9;
  localparam int FD  = 16;
  localparam int DW  = 16;
  localparam int BB  = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  baud_div = '0;
  logic [3:0]     cfg_data_bits = 4'd8;
  logic [1:0]     cfg_parity = 2'd0;
  logic           cfg_stop2 = 1'b0;
  logic [MDB-1:0] wr_data = '0;
  logic           wr_valid = 1'b0;
  logic           brk_req = 1'b0;
  wire            wr_ready, brk_done, tx, busy, frame_done;
  wire  [4:0]     fifo_count;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int bd_cnt = 0;

  uart_tx_framed #(
    .MAX_DATA_BITS(MDB), .FIFO_DEPTH(FD), .DIV_WIDTH(DW), .BREAK_BITS(BB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .brk_req(brk_req), .brk_done(brk_done), .tx(tx), .busy(busy),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (brk_done === 1'b1)   bd_cnt <= bd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [MDB-1:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Waits up to max_wait cycles for the first low cycle, then checks every cycle of nb bits.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nb,
                           input int div, input int max_wait, input bit use_brk);
    int  w = 0;
    logic pulse;
    while (tx !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_sof"}, 32'(tx), 32'd0);
    if (tx !== 1'b0) return;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j <= div; j++) begin
        pulse = use_brk ? brk_done : frame_done;
        check($sformatf("%s_tx_b%0d", tag, i), 32'(tx), 32'(bits[i]));
        check($sformatf("%s_busy_b%0d", tag, i), 32'(busy), 32'd1);
        check($sformatf("%s_pulse_b%0d", tag, i), 32'(pulse), 32'((i == nb - 1) && (j == div)));
        @(negedge clk);
      end
    end
    $display("TXN %s bits=%0d div=%0d", tag, nb, div);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_bd", 32'(brk_done), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, div 3, 0xA5; also checks push-to-start latency.
    baud_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    push(9'h0A5);
    check("lat_tx_hi", 32'(tx), 32'd1);
    check("lat_cnt1", 32'(fifo_count), 32'd1);
    @(negedge clk);
    check("lat_cnt0", 32'(fifo_count), 32'd0);
    f0 = fd_cnt;
    run_frame("a5_8n1", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 3, 0, 1'b0);
    check("a5_fd_once", 32'(fd_cnt - f0), 32'd1);
    check("a5_idle_busy", 32'(busy), 32'd0);
    check("a5_idle_tx", 32'(tx), 32'd1);

    // 8E2, div 0, 0x07; baud_div changed mid-frame must not take effect.
    baud_div = 16'd0; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    push(9'h007);
    @(negedge clk);
    baud_div = 16'd5;
    run_frame("07_8e2", {4'b0, 3'b111, 8'h07, 1'b0}, 12, 0, 0, 1'b0);
    check("07_idle_busy", 32'(busy), 32'd0);

    // 5O1 with upper bits ignored.
    baud_div = 16'd1; cfg_data_bits = 4'd5; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
    push(9'h1FF);
    run_frame("1ff_5o1", {8'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 8, 1, 4, 1'b0);

    // Data-bit clamping: 15 -> 9 bits, 2 -> 5 bits; parity code 3 means none.
    baud_div = 16'd0; cfg_data_bits = 4'd15; cfg_parity = 2'd3;
    push(9'h155);
    run_frame("155_9n1", {5'b0, 1'b1, 9'h155, 1'b0}, 11, 0, 4, 1'b0);
    cfg_data_bits = 4'd2;
    push(9'h1E5);
    run_frame("1e5_5n1", {9'b0, 1'b1, 5'h05, 1'b0}, 7, 0, 4, 1'b0);

    // Fill the FIFO, drop one push while full, then expect gapless frames.
    baud_div = 16'd7; cfg_data_bits = 4'd5; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          wr_data  = 9'(i);
          wr_valid = 1'b1;
          @(negedge clk);
        end
        wr_valid = 1'b0;
        check("fill_cnt", 32'(fifo_count), 32'd16);
        check("fill_ready", 32'(wr_ready), 32'd0);
        wr_data  = 9'h01B;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("drop_cnt", 32'(fifo_count), 32'd16);
      end
      begin
        for (int k = 0; k < 17; k++)
          run_frame($sformatf("b2b%0d", k), {9'b0, 1'b1, 5'(k), 1'b0}, 7, 7,
                    (k == 0) ? 4 : 0, 1'b0);
      end
    join
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_cnt", 32'(fifo_count), 32'd0);
    check("drain_tx", 32'(tx), 32'd1);

`ifdef UART_TX_BREAK_EN
    baud_div = 16'd1;
    f0 = bd_cnt;
    brk_req = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    run_frame("brk", {3'b0, 1'b1, 12'b0}, 13, 1, 2, 1'b1);
    check("brk_once", 32'(bd_cnt - f0), 32'd1);
    check("brk_idle_busy", 32'(busy), 32'd0);
`else
    brk_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("nobrk_tx", 32'(tx), 32'd1);
      check("nobrk_busy", 32'(busy), 32'd0);
      check("nobrk_done", 32'(brk_done), 32'd0);
    end
    brk_req = 1'b0;
    $display("TXN nobrk ignored");
`endif

    // Reset mid-data with three entries queued.
    baud_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data  = '0;
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("pre_rst_cnt", 32'(fifo_count), 32'd3);
    repeat (6) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    f0 = fd_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_cnt", 32'(fifo_count), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    check("post_rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_no_fd", 32'(fd_cnt - f0), 32'd0);
    check("post_rst_idle_tx", 32'(tx), 32'd1);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    $display("TXN reset_mid_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
